adc_triggered_capture: RTL and testbench
========================================

Name: adc_triggered_capture

Overview:
- Custom Qsys component sitting directly downstream of the modular ADC sequencer's Avalon-ST sample output.
- Filters one ADC channel and keeps a circular pre-trigger history. On a level-crossing trigger it fills a post-trigger window, then freezes the buffer and raises the complete conduit.
- Host software reaches control/status registers and buffer readback through the SPI-to-Avalon-MM bridge, via this block's Avalon-MM slave.

Parameters:
- DEPTH, 1024, sample buffer depth; power of two, 16..4096.
- DATA_W, 12, ADC sample width.
- CH_W, 5, ADC channel field width.
- PTR_W, log2(DEPTH), buffer index width (derived, do not override).

Ports:
- clk  in  1  component clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- adc_valid  in  1  Avalon-ST sink valid (no ready; sink always accepts).
- adc_channel  in  CH_W  Avalon-ST sink channel.
- adc_data  in  DATA_W  Avalon-ST sink sample.
- avs_address  in  PTR_W+1  word address; MSB=1 selects buffer window, MSB=0 selects registers.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data; sample zero-extended.
- avs_readdatavalid  out  1  pulses exactly 2 cycles after the avs_read cycle.
- complete  out  1  conduit; high while state is DONE.

Behaviour:
- Reset:
  - state=IDLE; complete=0; avs_readdatavalid=0; avs_readdata=0.
  - wr_ptr=0; LEVEL=0; CHAN=0; PRETRIG=0; EDGE=0; START=0.
- Registers (word address, MSB=0):
  - 0 CTRL, write: bit0 ARM (self-clearing); bit1 FORCE (self-clearing); bit2 EDGE (0=rising, 1=falling, sticky).
  - 1 STATUS, read: [2:0] state code (IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4); bit8 complete.
  - 2 LEVEL [DATA_W-1:0] rw.
  - 3 CHAN [CH_W-1:0] rw.
  - 4 PRETRIG [PTR_W-1:0] rw; values above DEPTH-1 saturate to DEPTH-1 on write.
  - 5 START ro: buffer index of the oldest stored sample.
  - Unmapped addresses read 0; writes to them are ignored.
- Sample qualification: a qualified sample is adc_valid=1 with adc_channel==CHAN. Each qualified sample in PRE/WAIT/POST:
  - writes to mem[wr_ptr];
  - increments wr_ptr modulo DEPTH (natural wrap);
  - updates prev to the sample value.
- IDLE:
  - Nothing is stored.
  - ARM -> PRE: cnt=0, complete=0, first_flag=1.
- PRE:
  - cnt increments per qualified sample.
  - When cnt reaches PRETRIG, go to WAIT in the same cycle the count is hit.
  - PRETRIG=0 enters WAIT on the cycle after ARM.
- WAIT, per qualified sample:
  - trig = !first_flag && (EDGE=0 ? prev<LEVEL && cur>=LEVEL : prev>LEVEL && cur<=LEVEL); comparison is unsigned.
  - first_flag clears after the first qualified sample.
- WAIT -> POST on trig or FORCE:
  - START = (trigger-sample index − PRETRIG) mod DEPTH.
  - The trigger sample is stored.
  - post_cnt = DEPTH − PRETRIG − 1 remaining.
  - FORCE with no coincident sample takes trigger index = wr_ptr.
- POST:
  - Each qualified sample decrements post_cnt.
  - At 0 -> DONE; the final sample is written in the transition cycle.
- DONE:
  - Buffer is frozen; complete=1; qualified samples are ignored.
  - ARM -> PRE.
- Simultaneous events:
  - ARM in any state restarts at PRE and wins over a coincident trigger or sample.
  - FORCE is ignored outside WAIT.
  - A register write changing LEVEL/EDGE/CHAN takes effect from the next cycle.
- Buffer read:
  - MSB=1, offset k returns mem[(START+k) mod DEPTH].
  - Reads are legal in any state; data is undefined unless DONE.
- Read pipeline:
  - 2-cycle latency: cycle 1 registers the address/mux; cycle 2 registers RAM/register output.
  - Back-to-back reads are fully pipelined; avs_readdata holds its value between pulses.
- Mid-operation reset returns to IDLE; buffer contents are not cleared.

Decomposition:
- Package adc_capture_pkg:
  - state enum codes;
  - register address constants (CTRL..START);
  - CTRL bit indices;
  - STATUS bit positions.
- One sub-module, capture_ram: simple dual-port RAM (DEPTH×DATA_W), one write port, registered read port, inferred as M9K.
- FSM, pointers and Avalon decode live in the top module.

Test Plan:
- Rising trigger, DEPTH=16, CHAN=2, LEVEL=100, PRETRIG=4, channel-2 ramp 0,10,20…; interleaved channel-1 samples=4095 -> trigger on sample value 100; complete=1 after 11 further channel-2 samples; buffer offsets 0..15 read 60,70,…,210; START=6.
- Falling edge with EDGE=1, LEVEL=50, descending ramp from 200 step 10 -> trigger at 50; offset PRETRIG holds 50; a first sample already below level does not trigger.
- FORCE in WAIT with constant input 7 -> POST entered; complete after DEPTH−PRETRIG−1 more samples; all readback=7; FORCE issued in IDLE leaves STATUS=0.
- Wrap-around: PRETRIG=15, DEPTH=16, 40 samples before trigger -> START=(trig_idx−15) mod 16; readback strictly ordered oldest→newest across the wrap.
- Re-arm and reset:
  - ARM during POST -> STATUS=1, complete=0, capture restarts.
  - reset asserted in WAIT -> STATUS=0, all registers return to their reset values.
- Readback timing: back-to-back reads of offsets 0,1,2 -> avs_readdatavalid high on cycles +2,+3,+4 with matching data; unmapped address 7 reads 0.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared state codes, register map and bit positions for the ADC triggered capture block.
package adc_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int unsigned ADDR_CTRL    = 32'd0;
  localparam int unsigned ADDR_STATUS  = 32'd1;
  localparam int unsigned ADDR_LEVEL   = 32'd2;
  localparam int unsigned ADDR_CHAN    = 32'd3;
  localparam int unsigned ADDR_PRETRIG = 32'd4;
  localparam int unsigned ADDR_START   = 32'd5;

  localparam int unsigned CTRL_ARM   = 32'd0;
  localparam int unsigned CTRL_FORCE = 32'd1;
  localparam int unsigned CTRL_EDGE  = 32'd2;

  localparam int unsigned STATUS_STATE_W  = 32'd3;
  localparam int unsigned STATUS_COMPLETE = 32'd8;

endpackage

// File: rtl/adc_triggered_capture_ram.sv
// Simple dual-port sample buffer: one write port and a registered read port (maps onto block RAM).
module capture_ram
  import adc_capture_pkg::*;
#(
  parameter int  DEPTH  = 1024,
  parameter int  DATA_W = 12,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_triggered_capture.sv
// Single-channel ADC capture with circular pre-trigger history, level-crossing trigger,
// post-trigger fill and an Avalon-MM slave for control, status and buffer readback.
module adc_triggered_capture
  import adc_capture_pkg::*;
#(
  parameter int  DEPTH  = 1024,
  parameter int  DATA_W = 12,
  parameter int  CH_W   = 5,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_valid,
  input  logic [CH_W-1:0]   adc_channel,
  input  logic [DATA_W-1:0] adc_data,
  input  logic [PTR_W:0]    avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              complete
);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, cnt_q, cnt_d, post_cnt_q, post_cnt_d;
  logic [PTR_W-1:0]   start_q, start_d, pretrig_q, pretrig_d, post_init_s;
  logic [DATA_W-1:0]  prev_q, prev_d, level_q, level_d;
  logic [CH_W-1:0]    chan_q, chan_d;
  logic               first_q, first_d, edge_q, edge_d, complete_q;
  logic               rd_v1_q, rd_buf_q, readdatavalid_q;
  logic [31:0]        rd_reg_q, reg_rdata_s, readdata_q;
  logic [DATA_W-1:0]  ram_rdata_s;
  logic [PTR_W-1:0]   reg_addr_s;
  logic               reg_wr_s, arm_s, force_s, qual_s, store_s, trig_s, rise_s, fall_s;

  assign reg_addr_s  = avs_address[PTR_W-1:0];
  assign reg_wr_s    = avs_write && !avs_address[PTR_W];
  assign arm_s       = reg_wr_s && (reg_addr_s == PTR_W'(ADDR_CTRL)) && avs_writedata[CTRL_ARM];
  assign force_s     = reg_wr_s && (reg_addr_s == PTR_W'(ADDR_CTRL)) && avs_writedata[CTRL_FORCE];
  assign qual_s      = adc_valid && (adc_channel == chan_q);
  assign rise_s      = (prev_q < level_q) && (adc_data >= level_q);
  assign fall_s      = (prev_q > level_q) && (adc_data <= level_q);
  assign trig_s      = qual_s && !first_q && (edge_q ? fall_s : rise_s);
  assign post_init_s = PTR_W'(DEPTH - 1) - pretrig_q;

  // Capture FSM next state; ARM overrides everything, including a coincident sample
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    post_cnt_d = post_cnt_q;
    first_d    = first_q;
    prev_d     = prev_q;
    start_d    = start_q;
    store_s    = 1'b0;
    if (arm_s) begin
      state_d = S_PRE;
      cnt_d   = {PTR_W{1'b0}};
      first_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_PRE: begin
          store_s = qual_s;
          if (qual_s) begin
            cnt_d = cnt_q + PTR_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
          if (cnt_d >= pretrig_q) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_PRE;
          end
        end
        S_WAIT: begin
          store_s = qual_s;
          if (qual_s) begin
            first_d = 1'b0;
          end else begin
            first_d = first_q;
          end
          if (trig_s || force_s) begin
            start_d    = wr_ptr_q - pretrig_q;
            post_cnt_d = post_init_s;
            // With a full pre-trigger history the trigger sample completes the window
            if (post_init_s == {PTR_W{1'b0}}) begin
              state_d = S_DONE;
            end else begin
              state_d = S_POST;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_POST: begin
          store_s = qual_s;
          if (qual_s) begin
            post_cnt_d = post_cnt_q - PTR_W'(1);
            if (post_cnt_d == {PTR_W{1'b0}}) begin
              state_d = S_DONE;
            end else begin
              state_d = S_POST;
            end
          end else begin
            state_d = S_POST;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
    if (store_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      prev_d   = adc_data;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Host register writes; PRETRIG saturates to the last buffer index
  always_comb begin
    level_d   = level_q;
    chan_d    = chan_q;
    pretrig_d = pretrig_q;
    edge_d    = edge_q;
    if (reg_wr_s) begin
      case (reg_addr_s)
        PTR_W'(ADDR_CTRL):  edge_d  = avs_writedata[CTRL_EDGE];
        PTR_W'(ADDR_LEVEL): level_d = avs_writedata[DATA_W-1:0];
        PTR_W'(ADDR_CHAN):  chan_d  = avs_writedata[CH_W-1:0];
        PTR_W'(ADDR_PRETRIG): begin
          if (avs_writedata > 32'(DEPTH - 1)) begin
            pretrig_d = PTR_W'(DEPTH - 1);
          end else begin
            pretrig_d = avs_writedata[PTR_W-1:0];
          end
        end
        default: level_d = level_q;
      endcase
    end else begin
      edge_d = edge_q;
    end
  end

  // Register read mux, captured in the first read pipeline stage
  always_comb begin
    reg_rdata_s = 32'd0;
    case (reg_addr_s)
      PTR_W'(ADDR_CTRL): reg_rdata_s[CTRL_EDGE] = edge_q;
      PTR_W'(ADDR_STATUS): begin
        reg_rdata_s[STATUS_STATE_W-1:0] = state_q;
        reg_rdata_s[STATUS_COMPLETE]    = complete_q;
      end
      PTR_W'(ADDR_LEVEL):   reg_rdata_s = 32'(level_q);
      PTR_W'(ADDR_CHAN):    reg_rdata_s = 32'(chan_q);
      PTR_W'(ADDR_PRETRIG): reg_rdata_s = 32'(pretrig_q);
      PTR_W'(ADDR_START):   reg_rdata_s = 32'(start_q);
      default:              reg_rdata_s = 32'd0;
    endcase
  end

  // State, configuration and read pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= {PTR_W{1'b0}};
      cnt_q           <= {PTR_W{1'b0}};
      post_cnt_q      <= {PTR_W{1'b0}};
      start_q         <= {PTR_W{1'b0}};
      pretrig_q       <= {PTR_W{1'b0}};
      prev_q          <= {DATA_W{1'b0}};
      level_q         <= {DATA_W{1'b0}};
      chan_q          <= {CH_W{1'b0}};
      first_q         <= 1'b0;
      edge_q          <= 1'b0;
      complete_q      <= 1'b0;
      rd_v1_q         <= 1'b0;
      rd_buf_q        <= 1'b0;
      rd_reg_q        <= 32'd0;
      readdatavalid_q <= 1'b0;
      readdata_q      <= 32'd0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      cnt_q           <= cnt_d;
      post_cnt_q      <= post_cnt_d;
      start_q         <= start_d;
      pretrig_q       <= pretrig_d;
      prev_q          <= prev_d;
      level_q         <= level_d;
      chan_q          <= chan_d;
      first_q         <= first_d;
      edge_q          <= edge_d;
      complete_q      <= (state_d == S_DONE);
      rd_v1_q         <= avs_read;
      rd_buf_q        <= avs_address[PTR_W];
      rd_reg_q        <= reg_rdata_s;
      readdatavalid_q <= rd_v1_q;
      if (rd_v1_q) begin
        readdata_q <= rd_buf_q ? 32'(ram_rdata_s) : rd_reg_q;
      end else begin
        readdata_q <= readdata_q;
      end
    end
  end

  capture_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (store_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (adc_data),
    .raddr_i (start_q + avs_address[PTR_W-1:0]),
    .rdata_o (ram_rdata_s)
  );

  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = readdatavalid_q;
  assign complete          = complete_q;

endmodule

// File: tb/tb_adc_triggered_capture.sv
// Self-checking bench: register table, directed capture sequences and randomized captures
// compared against a list-based model of the capture window.
module tb_adc_triggered_capture;
  localparam int DEPTH = 16, DATA_W = 12, CH_W = 5, PTR_W = 4, NV = 64;
  localparam logic [PTR_W:0] A_CTRL = 5'd0, A_STATUS = 5'd1, A_LEVEL = 5'd2, A_CHAN = 5'd3,
                             A_PRETRIG = 5'd4, A_START = 5'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, adc_valid, avs_read, avs_write, avs_readdatavalid, complete;
  logic [CH_W-1:0] adc_channel;
  logic [DATA_W-1:0] adc_data;
  logic [PTR_W:0] avs_address;
  logic [31:0] avs_writedata, avs_readdata;

  adc_triggered_capture #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset), .adc_valid(adc_valid), .adc_channel(adc_channel),
    .adc_data(adc_data), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .complete(complete)
  );

  int checks = 0, errors = 0;
  int cap[$];           // qualified samples stored since the last ARM
  int cap_base = 0;     // samples stored since reset at the time of ARM
  int stored_total = 0; // samples stored since reset (write index = this mod DEPTH)
  bit live = 1'b0;      // model: DUT currently stores qualified samples
  bit cur_edge = 1'b0;
  logic [CH_W-1:0] tgt_chan = 5'd0;
  int vals[NV];

  typedef struct {
    logic [PTR_W:0] addr;
    bit             wr;
    logic [31:0]    wdata;
    logic [31:0]    exp;
  } reg_vec_t;
  reg_vec_t tbl[14];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [PTR_W:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    cyc();
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [PTR_W:0] a, output logic [31:0] d, output int lat);
    avs_address = a; avs_read = 1'b1;
    cyc();
    avs_read = 1'b0;
    lat = 1;
    while (avs_readdatavalid !== 1'b1 && lat < 8) begin
      cyc();
      lat++;
    end
    if (avs_readdatavalid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%0d actual=no_valid required=valid", a);
    end
    d = avs_readdata;
  endtask

  task automatic rd_chk(input string name, input logic [PTR_W:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int lat;
    bus_read(a, d, lat);
    check(name, d, exp);
  endtask

  task automatic drive_sample(input logic [CH_W-1:0] ch, input int v);
    adc_channel = ch; adc_data = DATA_W'(v); adc_valid = 1'b1;
    cyc();
    adc_valid = 1'b0;
  endtask

  task automatic qs(input int v);
    drive_sample(tgt_chan, v);
    if (live) begin
      cap.push_back(v);
      stored_total++;
    end
  endtask

  task automatic idle_noise();
    adc_channel = tgt_chan; adc_data = DATA_W'($urandom_range(4095, 0)); adc_valid = 1'b0;
    cyc();
  endtask

  task automatic arm();
    reg_write(A_CTRL, {29'd0, cur_edge, 1'b0, 1'b1});
    cap.delete();
    cap_base = stored_total;
    live = 1'b1;
    cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    stored_total = 0; live = 1'b0; cur_edge = 1'b0;
  endtask

  // Window = PRETRIG samples before the trigger, the trigger, then the post samples
  task automatic verify_capture(input string name, input int t, input int p);
    rd_chk({name, "_status"}, A_STATUS, 32'h104);
    check({name, "_complete"}, {31'd0, complete}, 32'd1);
    rd_chk({name, "_start"}, A_START, 32'((cap_base + t - p) % DEPTH));
    for (int k = 0; k < DEPTH; k++)
      rd_chk($sformatf("%s_buf%0d", name, k), {1'b1, PTR_W'(k)}, 32'(cap[t - p + k]));
  endtask

  function automatic int find_trig(input int p, input int lev, input bit e);
    for (int j = p + 1; j < NV; j++) begin
      if (e ? (vals[j-1] > lev && vals[j] <= lev) : (vals[j-1] < lev && vals[j] >= lev))
        return j;
    end
    return -1;
  endfunction

  initial begin
    int t;
    logic [31:0] d;
    reset = 1'b1; adc_valid = 1'b0; adc_channel = '0; adc_data = '0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = 32'd0;
    repeat (3) cyc();
    reset = 1'b0;

    // Reset state and register table
    check("rst_complete", {31'd0, complete}, 32'd0);
    check("rst_rdvalid", {31'd0, avs_readdatavalid}, 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    tbl[0]  = '{A_STATUS,  1'b0, 32'd0, 32'd0};
    tbl[1]  = '{A_LEVEL,   1'b0, 32'd0, 32'd0};
    tbl[2]  = '{A_CHAN,    1'b0, 32'd0, 32'd0};
    tbl[3]  = '{A_PRETRIG, 1'b0, 32'd0, 32'd0};
    tbl[4]  = '{A_START,   1'b0, 32'd0, 32'd0};
    tbl[5]  = '{A_LEVEL,   1'b1, 32'h0ABC, 32'h0ABC};
    tbl[6]  = '{A_LEVEL,   1'b1, 32'hF123, 32'h0123};
    tbl[7]  = '{A_CHAN,    1'b1, 32'h3F, 32'h1F};
    tbl[8]  = '{A_PRETRIG, 1'b1, 32'd9, 32'd9};
    tbl[9]  = '{A_PRETRIG, 1'b1, 32'd16, 32'd15};
    tbl[10] = '{A_PRETRIG, 1'b1, 32'hFFFF_FFFF, 32'd15};
    tbl[11] = '{A_START,   1'b1, 32'd7, 32'd0};
    tbl[12] = '{5'd6,      1'b1, 32'h55, 32'd0};
    tbl[13] = '{5'd7,      1'b0, 32'd0, 32'd0};
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) reg_write(tbl[i].addr, tbl[i].wdata);
      rd_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
    end

    // Rising trigger on a ramp with interleaved foreign-channel samples
    tgt_chan = 5'd2;
    reg_write(A_CHAN, 32'd2); reg_write(A_LEVEL, 32'd100); reg_write(A_PRETRIG, 32'd4);
    arm();
    t = -1;
    for (int v = 0; v <= 210; v += 10) begin
      if (v == 100) t = cap.size();
      if (v == 210) check("ramp_complete_pre", {31'd0, complete}, 32'd0);
      qs(v);
      drive_sample(5'd1, 4095);
      if (v == 100) rd_chk("ramp_status_post", A_STATUS, 32'd3);
    end
    live = 1'b0;
    rd_chk("ramp_start_const", A_START, 32'd6);
    verify_capture("ramp", t, 4);
    qs(999);
    rd_chk("ramp_frozen", {1'b1, 4'd0}, 32'd60);

    // Falling trigger; a first WAIT sample already below level must not trigger
    reg_write(A_LEVEL, 32'd50);
    cur_edge = 1'b1;
    arm();
    for (int v = 200; v >= 170; v -= 10) qs(v);
    qs(40);
    rd_chk("fall_first_below", A_STATUS, 32'd2);
    for (int v = 200; v >= 50; v -= 10) begin
      if (v == 50) t = cap.size();
      qs(v);
    end
    rd_chk("fall_status_post", A_STATUS, 32'd3);
    for (int v = 49; v >= 39; v--) qs(v);
    live = 1'b0;
    rd_chk("fall_trig_slot", {1'b1, 4'd4}, 32'd50);
    verify_capture("fall", t, 4);

    // FORCE in IDLE is ignored; FORCE in WAIT with constant input
    do_reset();
    rd_chk("rst2_status", A_STATUS, 32'd0);
    reg_write(A_CTRL, 32'd2);
    rd_chk("force_idle_status", A_STATUS, 32'd0);
    reg_write(A_CHAN, 32'd2); reg_write(A_PRETRIG, 32'd4);
    arm();
    repeat (8) qs(7);
    rd_chk("force_wait_status", A_STATUS, 32'd2);
    t = cap.size();
    avs_address = A_CTRL; avs_writedata = 32'd2; avs_write = 1'b1;
    adc_channel = tgt_chan; adc_data = 12'd7; adc_valid = 1'b1;
    cyc();
    avs_write = 1'b0; adc_valid = 1'b0;
    cap.push_back(7); stored_total++;
    rd_chk("force_status_post", A_STATUS, 32'd3);
    repeat (10) qs(7);
    check("force_complete_pre", {31'd0, complete}, 32'd0);
    qs(7);
    live = 1'b0;
    verify_capture("force", t, 4);

    // Wrap-around with maximum pre-trigger history
    reg_write(A_PRETRIG, 32'd15); reg_write(A_LEVEL, 32'd100);
    arm();
    for (int i = 0; i < 40; i++) qs(10 + i);
    check("wrap_complete_pre", {31'd0, complete}, 32'd0);
    t = cap.size();
    qs(500);
    live = 1'b0;
    verify_capture("wrap", t, 15);

    // ARM during POST restarts the capture
    reg_write(A_PRETRIG, 32'd4);
    arm();
    for (int v = 0; v <= 130; v += 10) qs(v);
    rd_chk("rearm_in_post", A_STATUS, 32'd3);
    arm();
    rd_chk("rearm_status", A_STATUS, 32'd1);
    check("rearm_complete", {31'd0, complete}, 32'd0);
    for (int v = 0; v <= 210; v += 10) begin
      if (v == 100) t = cap.size();
      qs(v);
    end
    live = 1'b0;
    verify_capture("rearm", t, 4);

    // Back-to-back reads of offsets 0,1,2
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        avs_address = {1'b1, PTR_W'(c)}; avs_read = 1'b1;
      end else begin
        avs_read = 1'b0;
      end
      cyc();
      check($sformatf("b2b_valid%0d", c + 1), {31'd0, avs_readdatavalid},
            (c + 1 >= 2 && c + 1 <= 4) ? 32'd1 : 32'd0);
      if (c + 1 >= 2)
        check($sformatf("b2b_data%0d", c + 1), avs_readdata,
              32'(cap[t - 4 + ((c + 1 <= 4) ? c - 1 : 2)]));
    end

    // Reset in WAIT returns everything to reset values
    arm();
    for (int v = 0; v <= 50; v += 10) qs(v);
    rd_chk("rstw_pre_status", A_STATUS, 32'd2);
    do_reset();
    check("rstw_complete", {31'd0, complete}, 32'd0);
    rd_chk("rstw_status", A_STATUS, 32'd0);
    rd_chk("rstw_level", A_LEVEL, 32'd0);
    rd_chk("rstw_chan", A_CHAN, 32'd0);
    rd_chk("rstw_pretrig", A_PRETRIG, 32'd0);
    rd_chk("rstw_start", A_START, 32'd0);

    // Randomized captures against the list model
    for (int it = 0; it < 6; it++) begin
      int p, lev, ch;
      bit e;
      ch = $urandom_range(31, 0);
      p = $urandom_range(15, 0);
      lev = $urandom_range(3800, 200);
      e = 1'($urandom_range(1, 0));
      t = -1;
      for (int tries = 0; tries < 300 && t < 0; tries++) begin
        for (int i = 0; i < NV; i++) vals[i] = $urandom_range(4095, 0);
        t = find_trig(p, lev, e);
        if (t >= 0 && t + DEPTH - p > NV) t = -1;
      end
      if (t < 0) begin
        checks++; errors++;
        $display("FAIL rnd%0d_gen actual=no_trigger required=trigger", it);
        continue;
      end
      tgt_chan = 5'(ch);
      reg_write(A_CHAN, 32'(ch)); reg_write(A_LEVEL, 32'(lev)); reg_write(A_PRETRIG, 32'(p));
      cur_edge = e;
      arm();
      for (int i = 0; i < t + DEPTH - p; i++) begin
        if ($urandom_range(2, 0) == 0) drive_sample(5'(ch + 1), $urandom_range(4095, 0));
        if ($urandom_range(3, 0) == 0) idle_noise();
        if (i == t + DEPTH - p - 1)
          check($sformatf("rnd%0d_complete_pre", it), {31'd0, complete}, 32'd0);
        qs(vals[i]);
      end
      live = 1'b0;
      qs($urandom_range(4095, 0));
      qs($urandom_range(4095, 0));
      verify_capture($sformatf("rnd%0d", it), t, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
